// File: rtl/pll_reconfig_seq_if.sv
// Avalon-MM management bus between the PLL reconfiguration sequencer and the reconfig core.
interface pll_reconfig_seq_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] mgmt_address;
    logic              mgmt_write;
    logic [DATA_W-1:0] mgmt_writedata;
    logic              mgmt_read;
    logic [DATA_W-1:0] mgmt_readdata;
    logic              mgmt_waitrequest;

    modport master (
        output mgmt_address,
        output mgmt_write,
        output mgmt_writedata,
        output mgmt_read,
        input  mgmt_readdata,
        input  mgmt_waitrequest
    );

    modport slave (
        input  mgmt_address,
        input  mgmt_write,
        input  mgmt_writedata,
        input  mgmt_read,
        output mgmt_readdata,
        output mgmt_waitrequest
    );
endinterface

// File: rtl/pll_reconfig_seq.sv
// Buffers (address, data) PLL register writes, replays them to the reconfig core, triggers and qualifies lock.
// Optional build macro PLL_RCFG_POLL_EN selects polling mode (status read after trigger).
module pll_reconfig_seq #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ADDR_W       = 6,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned LOCK_TIMEOUT = 1000000,
    parameter int unsigned LOCK_STABLE  = 16
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    pll_reconfig_seq_if.master    mgmt,
    input  logic                  pll_locked
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned STB_W = $clog2(LOCK_STABLE + 1);

    localparam logic [ADDR_W-1:0] ADDR_MODE  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_START = ADDR_W'(2);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_MODE      = 3'd1;
    localparam logic [2:0] S_WRITE     = 3'd2;
    localparam logic [2:0] S_TRIG      = 3'd3;
    localparam logic [2:0] S_WAIT_LOCK = 3'd5;
    localparam logic [2:0] S_FINISH    = 3'd6;
`ifdef PLL_RCFG_POLL_EN
    localparam logic [2:0]        S_POLL      = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(1);
    localparam logic [DATA_W-1:0] MODE_VAL    = DATA_W'(1);
`else
    localparam logic [DATA_W-1:0] MODE_VAL    = DATA_W'(0);
`endif

    logic [2:0]        state, state_nxt;
    logic [CNT_W-1:0]  wptr, wptr_nxt, rptr, rptr_nxt;
    logic [TMO_W-1:0]  tmo, tmo_nxt;
    logic [STB_W-1:0]  stb, stb_nxt;
    logic              lock_s1, lock_s2;
    logic              busy_nxt, done_nxt, error_nxt, wr_ready_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt;
    logic              write_q, write_nxt;
    logic              read_q, read_nxt;
    logic              push_en;
    logic              xfer_done;
    logic              tmo_hit;
    logic              buf_empty;
    logic [CNT_W-1:0]  fill_nxt;
    logic              unused_rdata;

    logic [ADDR_W-1:0] buf_addr [DEPTH];
    logic [DATA_W-1:0] buf_data [DEPTH];

    assign xfer_done    = (write_q | read_q) & ~mgmt.mgmt_waitrequest;
    assign tmo_hit      = (tmo == TMO_W'(LOCK_TIMEOUT - 1));
    assign buf_empty    = (wptr == rptr);
    assign unused_rdata = ^mgmt.mgmt_readdata;

    assign mgmt.mgmt_address   = addr_q;
    assign mgmt.mgmt_writedata = wdata_q;
    assign mgmt.mgmt_write     = write_q;
    assign mgmt.mgmt_read      = read_q;

    // Entry storage; occupancy is tracked by the pointers, so no reset needed here.
    always_ff @(posedge refclk) begin
        if (push_en) begin
            buf_addr[wptr[PTR_W-1:0]] <= wr_addr;
            buf_data[wptr[PTR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wptr     <= '0;
            rptr     <= '0;
            tmo      <= '0;
            stb      <= '0;
            lock_s1  <= 1'b0;
            lock_s2  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            wr_ready <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            read_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wptr     <= wptr_nxt;
            rptr     <= rptr_nxt;
            tmo      <= tmo_nxt;
            stb      <= stb_nxt;
            lock_s1  <= pll_locked;
            lock_s2  <= lock_s1;
            busy     <= busy_nxt;
            done     <= done_nxt;
            error    <= error_nxt;
            wr_ready <= wr_ready_nxt;
            addr_q   <= addr_nxt;
            wdata_q  <= wdata_nxt;
            write_q  <= write_nxt;
            read_q   <= read_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wptr_nxt  = wptr;
        rptr_nxt  = rptr;
        tmo_nxt   = tmo;
        stb_nxt   = stb;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        error_nxt = error;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        write_nxt = write_q;
        read_nxt  = read_q;
        push_en   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    error_nxt = 1'b0;
                    if (buf_empty) begin
                        state_nxt = S_FINISH;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_MODE;
                        busy_nxt  = 1'b1;
                        write_nxt = 1'b1;
                        addr_nxt  = ADDR_MODE;
                        wdata_nxt = MODE_VAL;
                    end
                end else if (wr_valid && wr_ready) begin
                    push_en  = 1'b1;
                    wptr_nxt = wptr + CNT_W'(1);
                end
            end
            S_MODE, S_WRITE: begin
                // Next entry is loaded on the completing edge so writes run back-to-back.
                if (xfer_done) begin
                    if (buf_empty) begin
                        state_nxt = S_TRIG;
                        addr_nxt  = ADDR_START;
                        wdata_nxt = '0;
                    end else begin
                        state_nxt = S_WRITE;
                        addr_nxt  = buf_addr[rptr[PTR_W-1:0]];
                        wdata_nxt = buf_data[rptr[PTR_W-1:0]];
                        rptr_nxt  = rptr + CNT_W'(1);
                    end
                end
            end
            S_TRIG: begin
                if (xfer_done) begin
                    write_nxt = 1'b0;
                    tmo_nxt   = '0;
                    stb_nxt   = '0;
`ifdef PLL_RCFG_POLL_EN
                    state_nxt = S_POLL;
                    read_nxt  = 1'b1;
                    addr_nxt  = ADDR_STATUS;
`else
                    state_nxt = S_WAIT_LOCK;
`endif
                end
            end
`ifdef PLL_RCFG_POLL_EN
            S_POLL: begin
                tmo_nxt = tmo + TMO_W'(1);
                if (xfer_done && mgmt.mgmt_readdata[0]) begin
                    state_nxt = S_WAIT_LOCK;
                    read_nxt  = 1'b0;
                end else if (tmo_hit) begin
                    state_nxt = S_FINISH;
                    read_nxt  = 1'b0;
                    error_nxt = 1'b1;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    wptr_nxt  = '0;
                    rptr_nxt  = '0;
                end
            end
`endif
            S_WAIT_LOCK: begin
                tmo_nxt = tmo + TMO_W'(1);
                stb_nxt = lock_s2 ? stb + STB_W'(1) : '0;
                if (lock_s2 && (stb == STB_W'(LOCK_STABLE - 1))) begin
                    state_nxt = S_FINISH;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                end else if (tmo_hit) begin
                    state_nxt = S_FINISH;
                    error_nxt = 1'b1;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    wptr_nxt  = '0;
                    rptr_nxt  = '0;
                end
            end
            S_FINISH: begin
                state_nxt = S_IDLE;
                wptr_nxt  = '0;
                rptr_nxt  = '0;
                addr_nxt  = '0;
                wdata_nxt = '0;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        fill_nxt     = wptr_nxt - rptr_nxt;
        wr_ready_nxt = (state_nxt == S_IDLE) && (fill_nxt != CNT_W'(DEPTH));
    end
endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Bench for pll_reconfig_seq: transaction-level model checked every cycle plus directed literal checks.
module tb_pll_reconfig_seq;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LT     = 300;
    localparam int unsigned LS     = 16;
`ifdef PLL_RCFG_POLL_EN
    localparam logic [31:0] MODE_D = 32'h1;
`else
    localparam logic [31:0] MODE_D = 32'h0;
`endif

    logic              refclk = 1'b0;
    logic              rst_n;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              busy;
    logic              done;
    logic              error;
    logic              pll_locked;

    pll_reconfig_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mgmt ();

    pll_reconfig_seq #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS)
    ) dut (
        .refclk(refclk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy), .done(done), .error(error),
        .mgmt(mgmt), .pll_locked(pll_locked)
    );

    always #5 refclk = ~refclk;
    assign mgmt.mgmt_readdata = 32'h1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reconfig core: holds waitrequest for wait_n cycles on each write.
    int wait_n = 0;
    int wcnt   = 0;
    always @(negedge refclk) begin
        if (mgmt.mgmt_write && wcnt < wait_n) begin
            mgmt.mgmt_waitrequest = 1'b1;
            wcnt++;
        end else begin
            mgmt.mgmt_waitrequest = 1'b0;
            wcnt = 0;
        end
    end

    // Lock source: 0 low, 1 high, 2 toggles every 8 cycles.
    int lock_mode = 0;
    int tog = 0;
    always @(negedge refclk) begin
        case (lock_mode)
            0: pll_locked = 1'b0;
            1: pll_locked = 1'b1;
            default: begin
                tog++;
                if (tog == 8) begin
                    tog = 0;
                    pll_locked = ~pll_locked;
                end
            end
        endcase
    end

    // Behavioural model: host buffer, expected transfer list, lock/timeout qualification.
    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t mbuf[$];
    ent_t xq[$];
    int   m_phase;      // 0 idle, 1 bus transfers, 2 lock wait, 3 finish
    bit   e_busy, e_done, e_err, e_ready;
    int   m_tmo, m_stab;
    bit   [1:0] lh;
    bit   m_ls;
    ent_t tmp;

    always @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            mbuf.delete();
            xq.delete();
            m_phase = 0;
            e_busy = 0; e_done = 0; e_err = 0; e_ready = 1;
            lh = 2'b00; m_tmo = 0; m_stab = 0;
        end else begin
            m_ls = lh[1];
            lh = {lh[0], pll_locked === 1'b1};
            e_done = 0;
            case (m_phase)
                0: begin
                    if (start) begin
                        e_err = 0;
                        if (mbuf.size() == 0) begin
                            m_phase = 3;
                            e_done = 1;
                        end else begin
                            tmp.a = 6'h00; tmp.d = MODE_D;
                            xq.push_back(tmp);
                            foreach (mbuf[i]) xq.push_back(mbuf[i]);
                            tmp.a = 6'h02; tmp.d = 32'h0;
                            xq.push_back(tmp);
                            mbuf.delete();
                            m_phase = 1;
                            e_busy = 1;
                        end
                    end else if (wr_valid && e_ready) begin
                        tmp.a = wr_addr; tmp.d = wr_data;
                        mbuf.push_back(tmp);
                    end
                end
                1: begin
                    if (!mgmt.mgmt_waitrequest) begin
                        void'(xq.pop_front());
                        if (xq.size() == 0) begin
                            m_phase = 2; m_tmo = 0; m_stab = 0;
                        end
                    end
                end
                2: begin
                    m_tmo++;
                    m_stab = m_ls ? m_stab + 1 : 0;
                    if (m_stab == LS) begin
                        m_phase = 3; e_done = 1; e_busy = 0;
                    end else if (m_tmo == LT) begin
                        m_phase = 3; e_done = 1; e_busy = 0; e_err = 1;
                        mbuf.delete();
                    end
                end
                default: m_phase = 0;
            endcase
            e_ready = (m_phase == 0) && (mbuf.size() < DEPTH);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge refclk) begin
        if (rst_n) begin
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("error", error, e_err);
            chk("wr_ready", wr_ready, e_ready);
            chk("mgmt_write", mgmt.mgmt_write, m_phase == 1);
`ifndef PLL_RCFG_POLL_EN
            chk("mgmt_read", mgmt.mgmt_read, 0);
`endif
            if (m_phase == 1 && xq.size() > 0) begin
                chk("mgmt_address", mgmt.mgmt_address, xq[0].a);
                chk("mgmt_writedata", mgmt.mgmt_writedata, xq[0].d);
            end
        end
    end

    // Completed-write log and edge bookkeeping.
    int cyc = 0;
    int trig_edge = -1;
    int done_edge = -1;
    int done_cnt = 0;
    logic [37:0] wlog[$];
    always @(posedge refclk) begin
        if (rst_n && mgmt.mgmt_write && !mgmt.mgmt_waitrequest) begin
            wlog.push_back({mgmt.mgmt_address, mgmt.mgmt_writedata});
            if (mgmt.mgmt_address == 6'h02) trig_edge = cyc;
        end
        cyc++;
    end
    always @(negedge refclk) begin
        if (done) begin
            done_cnt++;
            done_edge = cyc - 1;
        end
    end

    task automatic push(input logic [5:0] a, input logic [31:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        @(negedge refclk);
        wr_valid = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge refclk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge refclk);
            if (done) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s done not seen within %0d cycles", name, budget);
        end
    endtask

    logic [5:0]  t1_a [5];
    logic [31:0] t1_d [5];
    int base;
    int d0;

    initial begin
        t1_a = '{6'h00, 6'h04, 6'h03, 6'h07, 6'h02};
        t1_d = '{MODE_D, 32'h0000_0404, 32'h0001_0000, 32'hE8F5_C28F, 32'h0};
        rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        repeat (3) @(negedge refclk);
        rst_n = 1'b1;
        @(negedge refclk);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_write", mgmt.mgmt_write, 0);
        chk("rst_address", mgmt.mgmt_address, 0);
        chk("rst_writedata", mgmt.mgmt_writedata, 0);

        // Three entries, lock rises 10 cycles after start.
        base = wlog.size(); d0 = done_cnt;
        push(6'h04, 32'h0000_0404);
        push(6'h03, 32'h0001_0000);
        push(6'h07, 32'hE8F5_C28F);
        start_pulse();
        repeat (9) @(negedge refclk);
        lock_mode = 1;
        wait_done("t1_done", LT + 50);
        chk("t1_error", error, 0);
        repeat (3) @(negedge refclk);
        chk("t1_nwrites", wlog.size() - base, 5);
        chk("t1_done_pulses", done_cnt - d0, 1);
        for (int i = 0; i < 5; i++) begin
            chk("t1_addr", wlog[base + i][37:32], t1_a[i]);
            chk("t1_data", wlog[base + i][31:0], t1_d[i]);
        end

        // Full buffer; the 17th push is dropped.
        base = wlog.size();
        for (int i = 0; i < 16; i++) push(6'(i + 8), 32'(i) * 32'h1111_0001);
        chk("t2_full_ready", wr_ready, 0);
        push(6'h3F, 32'hDEAD_BEEF);
        start_pulse();
        wait_done("t2_done", 300);
        repeat (2) @(negedge refclk);
        chk("t2_nwrites", wlog.size() - base, 18);
        chk("t2_last_entry", wlog[base + 16], {6'h17, 32'hFFFF_000F});

        // Five waitrequest cycles per write.
        wait_n = 5;
        base = wlog.size();
        push(6'h10, 32'hA5A5_0001);
        push(6'h11, 32'hA5A5_0002);
        push(6'h12, 32'hA5A5_0003);
        start_pulse();
        wait_done("t3_done", 300);
        wait_n = 0;
        repeat (2) @(negedge refclk);
        chk("t3_nwrites", wlog.size() - base, 5);
        chk("t3_entry2", wlog[base + 2], {6'h11, 32'hA5A5_0002});

        // Lock held low: timeout exactly LT cycles after the trigger write.
        lock_mode = 0;
        push(6'h05, 32'h1234_5678);
        push(6'h06, 32'h9ABC_DEF0);
        start_pulse();
        wait_done("t4_done", LT + 100);
        chk("t4_error", error, 1);
        @(negedge refclk);
        chk("t4_timeout_cycles", done_edge - trig_edge, LT);
        start_pulse();
        chk("t4_error_cleared", error, 0);
        chk("t4_empty_done", done, 1);
        repeat (2) @(negedge refclk);

        // Lock toggling every 8 cycles never qualifies.
        lock_mode = 2;
        push(6'h08, 32'h0000_0008);
        start_pulse();
        wait_done("t5_done", LT + 100);
        chk("t5_error", error, 1);
        lock_mode = 1;
        repeat (2) @(negedge refclk);

        // Reset in the middle of the entry writes.
        wait_n = 2;
        push(6'h20, 32'h0000_0020);
        push(6'h21, 32'h0000_0021);
        push(6'h22, 32'h0000_0022);
        push(6'h23, 32'h0000_0023);
        start_pulse();
        repeat (4) @(negedge refclk);
        chk("t6_in_write", mgmt.mgmt_write, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_error", error, 0);
        chk("t6_rst_write", mgmt.mgmt_write, 0);
        chk("t6_rst_address", mgmt.mgmt_address, 0);
        chk("t6_rst_writedata", mgmt.mgmt_writedata, 0);
        chk("t6_rst_wr_ready", wr_ready, 1);
        repeat (2) @(negedge refclk);
        rst_n = 1'b1;
        wait_n = 0;
        @(negedge refclk);
        base = wlog.size();
        start_pulse();
        chk("t6_empty_done", done, 1);
        @(negedge refclk);
        chk("t6_done_low", done, 0);
        repeat (2) @(negedge refclk);
        chk("t6_no_traffic", wlog.size() - base, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
